// File: rtl/exception_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// exception_controller
//
// Sequences exception entry and return for the LEGv8 pipeline. An exception
// request sampled in IDLE captures the faulting PC and cause, then walks the
// pipeline through a flush cycle and a redirect cycle to the vector. The
// handler runs until ERET, which flushes and redirects fetch back to ELR.
//
// Optional feature macro: EXC_DOUBLE_FAULT_EN
//   defined   : a non-IRQ exception inside the handler sets ESR to 4'b1111
//               and parks the controller in HALT until reset.
//   undefined : a non-IRQ exception inside the handler re-enters the
//               exception sequence; HALT is unreachable and Halted is 0.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   Exc        in   exception request from decoder
//   EStatus    in   [3:0] cause code (4'b0001 IRQ, 4'b0010 illegal insn)
//   ERet       in   ERET instruction in decode
//   PC_in      in   [N-1:0] PC of the decode-stage instruction
//   Flush      out  squash IF/ID/EX
//   PCSel_exc  out  fetch selects PCexc
//   PCexc      out  [N-1:0] redirect target
//   ExcAck     out  one-cycle pulse on vector redirect
//   InExc      out  handler running
//   ELR        out  [N-1:0] exception link register
//   ESR        out  [3:0] exception status register
//   ExcCount   out  [7:0] saturating count of exceptions taken
//   Halted     out  double-fault halt
//
// All outputs are registers loaded from the decode of the next state, so
// each output reflects the state held during the same cycle.
// -----------------------------------------------------------------------------
module exception_controller #(
    parameter int           N      = 64,
    parameter logic [N-1:0] VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic [N-1:0] PC_in,
    output logic         Flush,
    output logic         PCSel_exc,
    output logic [N-1:0] PCexc,
    output logic         ExcAck,
    output logic         InExc,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic [7:0]   ExcCount,
    output logic         Halted
);

    localparam logic [3:0] CAUSE_IRQ    = 4'b0001;
    localparam logic [3:0] CAUSE_DFAULT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [N-1:0] elr_r;
    logic [N-1:0] elr_next_s;
    logic [3:0]   esr_r;
    logic [3:0]   esr_next_s;
    logic [7:0]   cnt_r;
    logic [7:0]   cnt_next_s;

    logic         flush_r;
    logic         pcsel_r;
    logic [N-1:0] pcexc_r;
    logic         ack_r;
    logic         inexc_r;
    logic         flush_next_s;
    logic         pcsel_next_s;
    logic [N-1:0] pcexc_next_s;
    logic         ack_next_s;
    logic         inexc_next_s;

    // Saturating increment: the exception counter sticks at 8'hFF.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state and exception-register update logic.
    always_comb begin
        state_next_s = state_r;
        elr_next_s   = elr_r;
        esr_next_s   = esr_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                // A lone ERET outside a handler is a no-op.
                if (Exc) begin
                    elr_next_s   = PC_in;
                    esr_next_s   = EStatus;
                    cnt_next_s   = sat_inc(cnt_r);
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_next_s = ST_HANDLER;
            end
            ST_HANDLER: begin
                // A held IRQ line is ignored here; any other cause is a
                // nested fault and takes priority over a concurrent ERET.
                if (Exc && (EStatus != CAUSE_IRQ)) begin
`ifdef EXC_DOUBLE_FAULT_EN
                    esr_next_s   = CAUSE_DFAULT;
                    state_next_s = ST_HALT;
`else
                    elr_next_s   = PC_in;
                    esr_next_s   = EStatus;
                    cnt_next_s   = sat_inc(cnt_r);
                    state_next_s = ST_FLUSH;
`endif
                end else if (ERet && !Exc) begin
                    state_next_s = ST_RETURN;
                end else begin
                    state_next_s = ST_HANDLER;
                end
            end
            ST_RETURN: begin
                state_next_s = ST_IDLE;
            end
            ST_HALT: begin
`ifdef EXC_DOUBLE_FAULT_EN
                state_next_s = ST_HALT;
`else
                state_next_s = ST_IDLE;
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the state being entered, registered below.
    always_comb begin
        flush_next_s = 1'b0;
        pcsel_next_s = 1'b0;
        pcexc_next_s = {N{1'b0}};
        ack_next_s   = 1'b0;
        inexc_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                flush_next_s = 1'b0;
            end
            ST_FLUSH: begin
                flush_next_s = 1'b1;
            end
            ST_REDIRECT: begin
                flush_next_s = 1'b1;
                pcsel_next_s = 1'b1;
                pcexc_next_s = VECTOR;
                ack_next_s   = 1'b1;
            end
            ST_HANDLER: begin
                inexc_next_s = 1'b1;
            end
            ST_RETURN: begin
                flush_next_s = 1'b1;
                pcsel_next_s = 1'b1;
                pcexc_next_s = elr_next_s;
                inexc_next_s = 1'b1;
            end
            ST_HALT: begin
                flush_next_s = 1'b1;
                inexc_next_s = 1'b1;
            end
            default: begin
                flush_next_s = 1'b0;
            end
        endcase
    end

    // State, exception registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            elr_r   <= {N{1'b0}};
            esr_r   <= 4'b0000;
            cnt_r   <= 8'h00;
            flush_r <= 1'b0;
            pcsel_r <= 1'b0;
            pcexc_r <= {N{1'b0}};
            ack_r   <= 1'b0;
            inexc_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            elr_r   <= elr_next_s;
            esr_r   <= esr_next_s;
            cnt_r   <= cnt_next_s;
            flush_r <= flush_next_s;
            pcsel_r <= pcsel_next_s;
            pcexc_r <= pcexc_next_s;
            ack_r   <= ack_next_s;
            inexc_r <= inexc_next_s;
        end
    end

`ifdef EXC_DOUBLE_FAULT_EN
    logic halted_r;

    // Halt flag, set on entry to the double-fault state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_next_s == ST_HALT);
        end
    end

    assign Halted = halted_r;
`else
    assign Halted = 1'b0;
`endif

    assign Flush     = flush_r;
    assign PCSel_exc = pcsel_r;
    assign PCexc     = pcexc_r;
    assign ExcAck    = ack_r;
    assign InExc     = inexc_r;
    assign ELR       = elr_r;
    assign ESR       = esr_r;
    assign ExcCount  = cnt_r;

endmodule

// File: tb/tb_exception_controller.sv
`timescale 1ns/1ps
// Self-checking bench for exception_controller: a reference model predicts
// the outputs visible in each cycle and queues them; a monitor pops and
// compares on every falling edge.
module tb_exception_controller;

    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    typedef struct packed {
        logic        flush;
        logic        pcsel;
        logic [63:0] pcexc;
        logic        ack;
        logic        inexc;
        logic [63:0] elr;
        logic [3:0]  esr;
        logic [7:0]  cnt;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Exc;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] PC_in;
    logic        Flush;
    logic        PCSel_exc;
    logic [63:0] PCexc;
    logic        ExcAck;
    logic        InExc;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic [7:0]  ExcCount;
    logic        Halted;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_seen = 0;
    exp_t q[$];

    // Reference model: phase of the exception sequence plus the architectural
    // registers it owns.
    localparam int P_IDLE = 0, P_FLUSH = 1, P_REDIR = 2, P_HAND = 3, P_RET = 4, P_HALT = 5;
    int          m_phase;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    int          m_taken;

    exception_controller #(.N(64), .VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .Exc(Exc), .EStatus(EStatus), .ERet(ERet),
        .PC_in(PC_in), .Flush(Flush), .PCSel_exc(PCSel_exc), .PCexc(PCexc),
        .ExcAck(ExcAck), .InExc(InExc), .ELR(ELR), .ESR(ESR),
        .ExcCount(ExcCount), .Halted(Halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t m_expect();
        exp_t e;
        e        = '0;
        e.elr    = m_elr;
        e.esr    = m_esr;
        e.cnt    = (m_taken > 255) ? 8'hFF : 8'(m_taken);
        e.flush  = (m_phase == P_FLUSH) || (m_phase == P_REDIR) || (m_phase == P_RET) || (m_phase == P_HALT);
        e.pcsel  = (m_phase == P_REDIR) || (m_phase == P_RET);
        e.ack    = (m_phase == P_REDIR);
        e.inexc  = (m_phase == P_HAND) || (m_phase == P_RET) || (m_phase == P_HALT);
        e.halted = (m_phase == P_HALT);
        if (m_phase == P_REDIR) e.pcexc = VEC;
        else if (m_phase == P_RET) e.pcexc = m_elr;
        else e.pcexc = 64'd0;
        return e;
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE;
        m_elr   = 64'd0;
        m_esr   = 4'd0;
        m_taken = 0;
    endtask

    task automatic m_take(input logic [3:0] es, input logic [63:0] pc);
        m_elr   = pc;
        m_esr   = es;
        m_taken = m_taken + 1;
        m_phase = P_FLUSH;
    endtask

    // One rising edge of the reference behaviour.
    task automatic m_clock(input bit e, input logic [3:0] es, input bit r, input logic [63:0] pc);
        case (m_phase)
            P_IDLE:  if (e) m_take(es, pc);
            P_FLUSH: m_phase = P_REDIR;
            P_REDIR: m_phase = P_HAND;
            P_HAND: begin
                if (e && es != 4'b0001) begin
`ifdef EXC_DOUBLE_FAULT_EN
                    m_esr   = 4'b1111;
                    m_phase = P_HALT;
`else
                    m_take(es, pc);
`endif
                end else if (r && !e) begin
                    m_phase = P_RET;
                end
            end
            P_RET:   m_phase = P_IDLE;
            P_HALT:  m_phase = P_HALT;
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Drive one cycle of inputs; with arst the reset is pulled low 2 ns after
    // the edge, while the new state is already showing.
    task automatic step(input bit e, input logic [3:0] es, input bit r, input logic [63:0] pc, input bit arst);
        Exc = e; EStatus = es; ERet = r; PC_in = pc;
        if (!reset) m_reset();
        else m_clock(e, es, r, pc);
        if (arst) begin
            @(posedge clk);
            #2;
            reset = 1'b0;
            m_reset();
            q.push_back(m_expect());
        end else begin
            q.push_back(m_expect());
            @(posedge clk);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0);
    endtask

    // Monitor: compare each cycle's outputs with the oldest prediction.
    initial begin
        exp_t got, want;
        forever begin
            @(negedge clk);
            got = '{Flush, PCSel_exc, PCexc, ExcAck, InExc, ELR, ESR, ExcCount, Halted};
            if (ExcAck === 1'b1) ack_seen++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: no prediction queued", $time);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got flush=%b pcsel=%b pcexc=%h ack=%b inexc=%b elr=%h esr=%h cnt=%h halt=%b expected flush=%b pcsel=%b pcexc=%h ack=%b inexc=%b elr=%h esr=%h cnt=%h halt=%b",
                             $time, got.flush, got.pcsel, got.pcexc, got.ack, got.inexc, got.elr, got.esr, got.cnt, got.halted,
                             want.flush, want.pcsel, want.pcexc, want.ack, want.inexc, want.elr, want.esr, want.cnt, want.halted);
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_before;
        logic [3:0] es;
        reset = 1'b0; Exc = 1'b0; EStatus = 4'd0; ERet = 1'b0; PC_in = 64'd0;
        m_reset();
        q.push_back(m_expect());
        @(negedge clk); #1;
        idle_steps(1);
        reset = 1'b1;

        // ERET outside a handler changes nothing.
        step(1'b0, 4'd0, 1'b1, 64'h1234, 1'b0);
        step(1'b0, 4'd0, 1'b1, 64'h5678, 1'b0);

        // Illegal opcode at 0x40; inputs toggled during flush/redirect are ignored.
        step(1'b1, 4'b0010, 1'b0, 64'h40, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 64'h99, 1'b0);
        step(1'b1, 4'b0001, 1'b1, 64'h77, 1'b0);
        idle_steps(2);
        // Return through ELR.
        step(1'b0, 4'd0, 1'b1, 64'h88, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 64'h66, 1'b0);
        idle_steps(1);

        // IRQ held high for the whole handler: a single acknowledge.
        acks_before = ack_seen;
        step(1'b1, 4'b0001, 1'b0, 64'h80, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0001, (i % 2) == 1, 64'h100 + 64'(i), 1'b0);
        n_checks++;
        if (ack_seen - acks_before != 1) begin
            n_fail++;
            $display("FAIL irq_single_ack: got %0d acknowledges, expected 1", ack_seen - acks_before);
        end
        step(1'b0, 4'd0, 1'b1, 64'd0, 1'b0);
        idle_steps(2);

        // Nested illegal opcode together with ERET inside the handler.
        step(1'b1, 4'b0010, 1'b0, 64'h200, 1'b0);
        idle_steps(3);
        step(1'b1, 4'b0010, 1'b1, 64'h300, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, (i == 3), 64'd0, 1'b0);

        // Asynchronous reset while the redirect is on the outputs.
        step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1);
        idle_steps(1);
        reset = 1'b1;
        step(1'b1, 4'b0010, 1'b0, 64'h400, 1'b0);
        step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1);
        idle_steps(1);
        reset = 1'b1;

        // 300 back-to-back entry/return sequences: counter saturates.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'b0010, 1'b0, {$urandom, $urandom}, 1'b0);
            idle_steps(2);
            step(1'b0, 4'd0, 1'b1, 64'd0, 1'b0);
            idle_steps(1);
        end
        step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1);
        idle_steps(1);
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: es = 4'b0001;
                1: es = 4'b0010;
                default: es = 4'($urandom);
            endcase
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1);
                idle_steps(1);
                reset = 1'b1;
            end else begin
                step($urandom_range(0, 3) == 0, es, $urandom_range(0, 2) == 0, {$urandom, $urandom}, 1'b0);
            end
        end
        idle_steps(2);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
